// File: rtl/dispatcher_pkg.sv
// Shared lane-selection helpers for the 1-to-N stream dispatcher.
// Pure functions only; no state.
package dispatcher_pkg;
   localparam int MAX_LANES = 32;

   // Lane-index register width, kept at least one bit so N=1 still elaborates.
   function automatic int lane_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One-hot pick of the first free lane, searching upward from lowest_prio+1 (mod n).
   function automatic logic [MAX_LANES-1:0] rotating_first_free(
      input logic [MAX_LANES-1:0] free,
      input int                   lowest_prio,
      input int                   n
   );
      logic [MAX_LANES-1:0] grant;
      logic                 found;
      int                   idx;
      grant = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_LANES; k++) begin
         if (k <= n && !found) begin
            idx = lowest_prio + k;
            if (idx >= n) idx = idx - n;
            if (free[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
      return grant;
   endfunction
endpackage

// File: rtl/dispatcher_fixed_shiftable_dispatch_logic.sv
// Rotating-priority lane grant plus the lowest-priority pointer (DISPATCHER_AUTO_SHIFT_EN: round-robin).
// Latency: grant is combinational; pointer updates on the clock edge.
// Backpressure: grant is all-zero when no lane is free.
module dispatch_logic_fixed_shiftable
   import dispatcher_pkg::*;
#(
   parameter int N                = 2,
   parameter int INIT_LOWEST_PRIO = N - 1
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef DISPATCHER_AUTO_SHIFT_EN
   input  logic         accept,
`endif
   input  logic         shift,
   input  logic [N-1:0] free,
   output logic [N-1:0] grant
);
   localparam int LW = lane_idx_w(N);

   logic [LW-1:0] lowest_prio;

   assign grant = N'(rotating_first_free(MAX_LANES'(free), int'(lowest_prio), N));

   generate
      if (N == 1) begin : g_single
         assign lowest_prio = '0;
      end else begin : g_multi
         logic [LW-1:0] rotated;
         assign rotated = (lowest_prio == LW'(N - 1)) ? '0 : lowest_prio + LW'(1);
`ifdef DISPATCHER_AUTO_SHIFT_EN
         logic [LW-1:0] grant_idx;
         always_comb begin
            grant_idx = '0;
            for (int i = 0; i < N; i++)
               if (grant[i]) grant_idx = LW'(i);
         end
`endif
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lowest_prio <= LW'(INIT_LOWEST_PRIO);
`ifdef DISPATCHER_AUTO_SHIFT_EN
            end else if (accept) begin
               // The lane just served drops to the back of the queue; beats a same-cycle shift.
               lowest_prio <= grant_idx;
`endif
            end else if (shift) begin
               lowest_prio <= rotated;
            end
         end
      end
   endgenerate
endmodule

// File: rtl/dispatcher_fixed_shiftable.sv
// 1-to-N stream dispatcher: each accepted word lands in one free lane register (DISPATCHER_AUTO_SHIFT_EN: round-robin).
// Latency: word visible on out_valid/out_data the cycle after acceptance.
// Backpressure: in_ready low only when every lane is full and not being drained.
module dispatcher_fixed_shiftable
   import dispatcher_pkg::*;
#(
   parameter int DWIDTH           = 16,
   parameter int N                = 2,
   parameter int INIT_LOWEST_PRIO = N - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   input  logic              shift,
   output logic              out_valid [N-1:0],
   output logic [DWIDTH-1:0] out_data  [N-1:0],
   input  logic              out_ready [N-1:0]
);
   logic              hold_valid [N-1:0];
   logic [DWIDTH-1:0] hold_data  [N-1:0];
   logic [N-1:0]      free;
   logic [N-1:0]      grant;
   logic              accept;

   // A lane draining this cycle can be refilled in the same cycle.
   always_comb begin
      free = '0;
      for (int i = 0; i < N; i++)
         free[i] = !hold_valid[i] | out_ready[i];
   end

   assign in_ready  = |free;
   assign accept    = in_valid & in_ready;
   assign out_valid = hold_valid;
   assign out_data  = hold_data;

   dispatch_logic_fixed_shiftable #(
      .N                (N),
      .INIT_LOWEST_PRIO (INIT_LOWEST_PRIO)
   ) u_dispatch_logic (
      .clk    (clk),
      .rst_n  (rst_n),
`ifdef DISPATCHER_AUTO_SHIFT_EN
      .accept (accept),
`endif
      .shift  (shift),
      .free   (free),
      .grant  (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            hold_valid[i] <= 1'b0;
            hold_data[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (accept && grant[i]) begin
               hold_valid[i] <= 1'b1;
               hold_data[i]  <= in_data;
            end else if (out_ready[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
      end
   end
endmodule
